// File: rtl/display_pkg.sv
// Display-wide geometry and colour constants shared by the video pipeline.
package display_pkg;

    localparam int RGB_W    = 12;
    localparam int X_POS_W  = 10;
    localparam int Y_POS_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/sprite_pkg.sv
// Sprite bounding-box type used between motion controllers and the display stage,
// plus the ball controller state type.
package sprite_pkg;

    import display_pkg::*;

    // right/bottom are exclusive edges: right = x_pos + width
    typedef struct packed {
        logic [X_POS_W-1:0] x_pos;
        logic [Y_POS_W-1:0] y_pos;
        logic [X_POS_W-1:0] right;
        logic [Y_POS_W-1:0] bottom;
    } sprite_t;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        PLAY
    } ball_state_t;

endpackage

// File: rtl/sprite_overlap.sv
// Pure combinational axis-aligned box test of two sprites; touching edges count as overlap.
module sprite_overlap
    import sprite_pkg::*;
(
    input  sprite_t a,
    input  sprite_t b,
    output logic    hit
);

    assign hit = (a.x_pos <= b.right)  && (b.x_pos <= a.right) &&
                 (a.y_pos <= b.bottom) && (b.y_pos <= a.bottom);

endmodule

// File: rtl/ball_motion.sv
// Frame-rate ball controller: holds the ball for a serve, then moves it once per frame,
// bouncing off walls and paddles and pulsing a score event when a side misses.
module ball_motion
    import sprite_pkg::*;
#(
    parameter int SCREEN_W     = display_pkg::SCREEN_W,
    parameter int SCREEN_H     = display_pkg::SCREEN_H,
    parameter int BALL_SIZE    = 8,
    parameter int SPEED_X      = 2,
    parameter int SPEED_Y      = 1,
    parameter int SERVE_FRAMES = 60
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    frame_tick_i,
    input  logic    start_i,
    input  sprite_t paddle_l_i,
    input  sprite_t paddle_r_i,
    output sprite_t ball_o,
    output logic    score_l_o,
    output logic    score_r_o,
    output logic    in_play_o
);

    localparam int XW    = display_pkg::X_POS_W;
    localparam int YW    = display_pkg::Y_POS_W;
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [XW-1:0]    X_CENTRE = XW'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [YW-1:0]    Y_CENTRE = YW'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [YW-1:0]    Y_FLOOR  = YW'(SCREEN_H - 1 - BALL_SIZE);
    localparam logic [XW-1:0]    STEP_X   = XW'(SPEED_X);
    localparam logic [YW-1:0]    STEP_Y   = YW'(SPEED_Y);
    localparam logic [XW-1:0]    BALL_X   = XW'(BALL_SIZE);
    localparam logic [YW-1:0]    BALL_Y   = YW'(BALL_SIZE);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    ball_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             dir_x_q, dir_x_d;
    logic             dir_y_q, dir_y_d;
    logic             score_l_q, score_l_d;
    logic             score_r_q, score_r_d;

    sprite_t          ball_box;
    sprite_t          sweep_box;
    logic             overlap_l, overlap_r;
    logic             miss_left_edge, miss_right_edge;
    logic             wall_top, wall_bottom;
    logic [XW-1:0]    snap_r;

    assign ball_box.x_pos  = x_q;
    assign ball_box.y_pos  = y_q;
    assign ball_box.right  = x_q + BALL_X;
    assign ball_box.bottom = y_q + BALL_Y;

    assign ball_o    = ball_box;
    assign score_l_o = score_l_q;
    assign score_r_o = score_r_q;
    assign in_play_o = (state_q == PLAY);

    // Edge tests carry one extra bit so the look-ahead sums can never wrap.
    assign miss_left_edge  = !dir_x_q && ({1'b0, x_q} < {1'b0, STEP_X});
    assign miss_right_edge =  dir_x_q &&
        (({1'b0, x_q} + (XW+1)'(BALL_SIZE + SPEED_X)) > (XW+1)'(SCREEN_W - 1));
    assign wall_top        = !dir_y_q && ({1'b0, y_q} < {1'b0, STEP_Y});
    assign wall_bottom     =  dir_y_q &&
        (({1'b0, y_q} + (YW+1)'(BALL_SIZE + SPEED_Y)) > (YW+1)'(SCREEN_H - 1));

    // The paddle test uses the box swept by this frame's step, extended only toward the motion.
    always_comb begin
        sweep_box = ball_box;
        if (dir_x_q) begin
            sweep_box.right = ball_box.right + STEP_X;
        end else begin
            sweep_box.x_pos = (x_q < STEP_X) ? '0 : x_q - STEP_X;
        end
    end

    sprite_overlap u_overlap_l (
        .a   (sweep_box),
        .b   (paddle_l_i),
        .hit (overlap_l)
    );

    sprite_overlap u_overlap_r (
        .a   (sweep_box),
        .b   (paddle_r_i),
        .hit (overlap_r)
    );

    assign snap_r = (paddle_r_i.x_pos < BALL_X) ? '0 : paddle_r_i.x_pos - BALL_X;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            x_q       <= X_CENTRE;
            y_q       <= Y_CENTRE;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
        end
    end

    // Score pulses default low, so they last exactly one cycle after the tick that set them.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        score_l_d = 1'b0;
        score_r_d = 1'b0;

        if (frame_tick_i) begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = SERVE;
                        cnt_d   = '0;
                    end
                end
                SERVE: begin
                    x_d   = X_CENTRE;
                    y_d   = Y_CENTRE;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == SERVE_LAST) begin
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    if (miss_left_edge || miss_right_edge) begin
                        score_r_d = miss_left_edge;
                        score_l_d = miss_right_edge;
                        dir_x_d   = miss_left_edge;
                        x_d       = X_CENTRE;
                        y_d       = Y_CENTRE;
                        cnt_d     = '0;
                        state_d   = SERVE;
                    end else begin
                        if (dir_x_q && overlap_r) begin
                            x_d     = snap_r;
                            dir_x_d = 1'b0;
                        end else if (!dir_x_q && overlap_l) begin
                            x_d     = paddle_l_i.right;
                            dir_x_d = 1'b1;
                        end else begin
                            x_d = dir_x_q ? x_q + STEP_X : x_q - STEP_X;
                        end

                        if (wall_top) begin
                            y_d     = '0;
                            dir_y_d = 1'b1;
                        end else if (wall_bottom) begin
                            y_d     = Y_FLOOR;
                            dir_y_d = 1'b0;
                        end else begin
                            y_d = dir_y_q ? y_q + STEP_Y : y_q - STEP_Y;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed serve/bounce/miss/reset scenarios followed
// by randomized play, all compared against an arithmetic model of the ball rules.
module tb_ball_motion;

    import sprite_pkg::*;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int BALL     = 8;
    localparam int SPX      = 2;
    localparam int SPY      = 1;
    localparam int SERVE    = 60;
    localparam int CX       = (SCREEN_W - BALL) / 2;
    localparam int CY       = (SCREEN_H - BALL) / 2;

    logic    clk = 1'b0;
    logic    rst_ni;
    logic    frame_tick_i;
    logic    start_i;
    sprite_t paddle_l;
    sprite_t paddle_r;
    sprite_t ball;
    logic    score_l;
    logic    score_r;
    logic    in_play;

    int errors = 0;
    int checks = 0;

    int bx, by, dx, dy, serve_left;
    bit m_serve, m_play, exp_sl, exp_sr;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .frame_tick_i (frame_tick_i),
        .start_i      (start_i),
        .paddle_l_i   (paddle_l),
        .paddle_r_i   (paddle_r),
        .ball_o       (ball),
        .score_l_o    (score_l),
        .score_r_o    (score_r),
        .in_play_o    (in_play)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic sprite_t absentPaddle();
        sprite_t p;
        p.x_pos  = 10'd0;
        p.y_pos  = 10'd1000;
        p.right  = 10'd8;
        p.bottom = 10'd1010;
        return p;
    endfunction

    function automatic sprite_t makePaddle(input int x, input int y);
        sprite_t p;
        p.x_pos  = 10'(x);
        p.y_pos  = 10'(y);
        p.right  = 10'(x + 8);
        p.bottom = 10'(y + 64);
        return p;
    endfunction

    function automatic bit touches(input int lo, input int hi, input int top, input int bot, input sprite_t p);
        return (lo <= int'(p.right)) && (int'(p.x_pos) <= hi) &&
               (top <= int'(p.bottom)) && (int'(p.y_pos) <= bot);
    endfunction

    task automatic modelReset();
        bx = CX; by = CY; dx = 1; dy = 1;
        m_serve = 0; m_play = 0; serve_left = 0;
        exp_sl = 0; exp_sr = 0;
    endtask

    task automatic modelServe();
        m_play = 0; m_serve = 1; serve_left = SERVE;
        bx = CX; by = CY;
    endtask

    task automatic modelTick(input bit start);
        int lo, hi;
        exp_sl = 0;
        exp_sr = 0;
        if (m_play) begin
            if (dx < 0 && bx < SPX) begin
                exp_sr = 1; dx = 1; modelServe();
            end else if (dx > 0 && bx + BALL + SPX > SCREEN_W - 1) begin
                exp_sl = 1; dx = -1; modelServe();
            end else begin
                lo = (dx > 0) ? bx : bx - SPX;
                hi = (dx > 0) ? bx + BALL + SPX : bx + BALL;
                if (dx > 0 && touches(lo, hi, by, by + BALL, paddle_r)) begin
                    bx = int'(paddle_r.x_pos) - BALL; dx = -1;
                end else if (dx < 0 && touches(lo, hi, by, by + BALL, paddle_l)) begin
                    bx = int'(paddle_l.right); dx = 1;
                end else begin
                    bx = bx + dx * SPX;
                end
                if (dy < 0 && by < SPY) begin
                    by = 0; dy = 1;
                end else if (dy > 0 && by + BALL + SPY > SCREEN_H - 1) begin
                    by = SCREEN_H - 1 - BALL; dy = -1;
                end else begin
                    by = by + dy * SPY;
                end
            end
        end else if (m_serve) begin
            serve_left--;
            if (serve_left == 0) begin
                m_serve = 0; m_play = 1;
            end
        end else if (start) begin
            modelServe();
        end
    endtask

    task automatic checkAll();
        checkOutput("x",       ball.x_pos,  bx);
        checkOutput("y",       ball.y_pos,  by);
        checkOutput("right",   ball.right,  bx + BALL);
        checkOutput("bottom",  ball.bottom, by + BALL);
        checkOutput("in_play", in_play,     m_play);
        checkOutput("score_l", score_l,     exp_sl);
        checkOutput("score_r", score_r,     exp_sr);
    endtask

    // One frame tick: drive on a falling edge, sample on the next falling edge.
    task automatic applyStimulus(input bit start);
        @(negedge clk);
        start_i      = start;
        frame_tick_i = 1'b1;
        modelTick(start);
        @(negedge clk);
        frame_tick_i = 1'b0;
        checkAll();
    endtask

    task automatic settle(input int idle);
        @(negedge clk);
        checkOutput("score_l_clear", score_l, 0);
        checkOutput("score_r_clear", score_r, 0);
        checkOutput("x_hold", ball.x_pos, bx);
        repeat (idle - 1) @(negedge clk);
    endtask

    task automatic resetNow();
        #2 rst_ni = 1'b0;
        modelReset();
        #1 checkAll();
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic startGame();
        applyStimulus(1'b1);
        settle(1);
        repeat (SERVE) begin
            applyStimulus(1'b0);
            settle(1);
        end
    endtask

    task automatic playUntilMiss(output bit found);
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            applyStimulus(1'b0);
            if (exp_sl || exp_sr) found = 1;
            else settle(1);
        end
        if (!found) checkOutput("miss_timeout", 0, 1);
    endtask

    initial begin
        bit found;
        int py;

        rst_ni       = 1'b0;
        frame_tick_i = 1'b0;
        start_i      = 1'b0;
        paddle_l     = absentPaddle();
        paddle_r     = absentPaddle();
        modelReset();
        #12;
        checkOutput("rst_x",       ball.x_pos,  316);
        checkOutput("rst_y",       ball.y_pos,  236);
        checkOutput("rst_in_play", in_play,     0);
        checkOutput("rst_score_l", score_l,     0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Idle ticks without start, then a serve and play until the ball leaves on the right.
        repeat (10) begin
            applyStimulus(1'b0);
            settle(1);
        end
        checkOutput("idle_right",  ball.right,  324);
        checkOutput("idle_bottom", ball.bottom, 244);
        checkOutput("idle_play",   in_play,     0);

        applyStimulus(1'b1);
        settle(1);
        for (int i = 1; i <= SERVE; i++) begin
            applyStimulus(1'b0);
            if (i == SERVE - 1) checkOutput("serve_59_play", in_play, 0);
            if (i == SERVE) begin
                checkOutput("serve_60_play", in_play, 1);
                checkOutput("serve_60_x", ball.x_pos, 316);
            end
            settle(1);
        end
        applyStimulus(1'b0);
        checkOutput("first_move_x", ball.x_pos, 318);
        checkOutput("first_move_y", ball.y_pos, 237);
        settle(1);

        playUntilMiss(found);
        checkOutput("miss_score_l", score_l, 1);
        checkOutput("miss_centre_x", ball.x_pos, 316);
        checkOutput("miss_in_play", in_play, 0);
        settle(1);

        // Right paddle spanning the screen height; then the floor bounce.
        resetNow();
        paddle_r = makePaddle(601, 0);
        paddle_r.bottom = 10'd479;
        startGame();
        for (int k = 1; k <= 240; k++) begin
            applyStimulus(1'b0);
            if (k == 139) checkOutput("paddle_snap_right", ball.right, 601);
            if (k == 140) checkOutput("paddle_away_x", ball.x_pos, 591);
            if (k == 235) checkOutput("floor_reach_y", ball.y_pos, 471);
            if (k == 236) checkOutput("floor_bounce_y", ball.y_pos, 471);
            if (k == 237) checkOutput("floor_after_y", ball.y_pos, 470);
            settle(1);
        end

        // Asynchronous reset mid-play, and again while a score pulse is pending.
        resetNow();
        paddle_r = absentPaddle();
        startGame();
        repeat (20) begin
            applyStimulus(1'b0);
            settle(1);
        end
        @(negedge clk);
        resetNow();
        checkOutput("midplay_rst_play", in_play, 0);
        startGame();
        playUntilMiss(found);
        resetNow();
        checkOutput("pulse_dropped", score_l, 0);

        // Randomized play with paddles that often sit in the ball's path.
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 3) == 0) paddle_l = absentPaddle();
                else begin
                    py = by - int'($urandom_range(0, 60));
                    py = (py < 0) ? 0 : ((py > 415) ? 415 : py);
                    paddle_l = makePaddle(int'($urandom_range(0, 40)), py);
                end
                if ($urandom_range(0, 3) == 0) paddle_r = absentPaddle();
                else begin
                    py = by - int'($urandom_range(0, 60));
                    py = (py < 0) ? 0 : ((py > 415) ? 415 : py);
                    paddle_r = makePaddle(int'($urandom_range(560, 630)), py);
                end
            end
            applyStimulus($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) resetNow();
            else settle(int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
